// File: rtl/simon_pkg.sv
// Shared types, z-sequence constants and rotate helpers for the Simon stream engine.
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    UNLOAD
  } state_e;

  typedef enum logic [1:0] {
    SEL_KEY = 2'b00,
    SEL_BLK = 2'b01,
    SEL_IV  = 2'b10,
    SEL_RSV = 2'b11
  } in_sel_e;

  // Leftmost literal bit is z[j][0], so bit r lives at [61-r].
  localparam logic [0:4][61:0] Z_SEQ = {
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  function automatic logic [63:0] rol(input logic [63:0] w, input int unsigned n,
                                      input int unsigned width);
    logic [63:0] msk;
    logic [63:0] wm;
    msk = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    wm  = w & msk;
    rol = ((wm << n) | (wm >> (width - n))) & msk;
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] w, input int unsigned n,
                                      input int unsigned width);
    ror = rol(w, width - n, width);
  endfunction

endpackage

// File: rtl/simon_round.sv
// One combinational Simon round: (x, y) -> (y ^ f(x) ^ k, x).
module simon_round
  import simon_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] k,
  output logic [N-1:0] x_n,
  output logic [N-1:0] y_n
);

  logic [N-1:0] f;

  always_comb begin
    f   = (N'(rol(64'(x), 1, N)) & N'(rol(64'(x), 8, N))) ^ N'(rol(64'(x), 2, N));
    x_n = y ^ f ^ k;
    y_n = x;
  end

endmodule

// File: rtl/simon_stream_core.sv
// Byte-serial Simon-2N/MN encryption engine, one round per cycle, on-the-fly key schedule.
// Define SIMON_CHAIN_EN to enable the IV register and CBC chaining.
module simon_stream_core
  import simon_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned M    = 4,
  parameter int unsigned T    = 32,
  parameter int unsigned ZSEQ = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_sel,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  localparam int unsigned KW = M * N;
  localparam int unsigned BW = 2 * N;
  localparam int unsigned NB = BW / 8;
  localparam int unsigned CW = $clog2(NB);
  localparam int unsigned RW = $clog2(T);
  localparam logic [61:0] ZC = Z_SEQ[ZSEQ];

  state_e          state_q, state_d;
  logic [KW-1:0]   key_q, key_d;
  logic [KW-1:0]   wk_q, wk_d;
  logic [BW-1:0]   blk_q, blk_d, blk_in;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rnd_q, rnd_d;
`ifdef SIMON_CHAIN_EN
  logic [BW-1:0]   iv_q, iv_d;
`endif
  logic [N-1:0]    x_n, y_n, tmp, knew;
  logic [5:0]      zi;

  simon_round #(.N(N)) u_round (
    .x  (blk_q[BW-1 -: N]),
    .y  (blk_q[N-1:0]),
    .k  (wk_q[N-1:0]),
    .x_n(x_n),
    .y_n(y_n)
  );

  // Working key register holds k[r..r+M-1]; low word is the current round key.
  always_comb begin
    zi   = 6'(32'(rnd_q) % 32'd62);
    tmp  = N'(ror(64'(wk_q[KW-1 -: N]), 3, N));
    if (M == 4) tmp = tmp ^ wk_q[2*N-1 -: N];
    tmp  = tmp ^ N'(ror(64'(tmp), 1, N));
    knew = ~wk_q[N-1:0] ^ tmp ^ N'(ZC[6'd61 - zi]) ^ N'(3);
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    wk_d    = wk_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
`ifdef SIMON_CHAIN_EN
    iv_d    = iv_q;
`endif
    blk_in    = {blk_q[BW-9:0], in_data};
    in_ready  = rst_n & ena & (state_q == IDLE);
    out_valid = ena & (state_q == UNLOAD);
    busy      = (state_q != IDLE);
    out_data  = (state_q == UNLOAD) ? 8'(blk_q >> (8 * (NB - 1 - 32'(cnt_q)))) : '0;

    if (ena) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            case (in_sel_e'(in_sel))
              SEL_KEY: begin
                key_d = {key_q[KW-9:0], in_data};
                cnt_d = '0;
              end
              SEL_BLK: begin
                if (cnt_q == CW'(NB - 1)) begin
`ifdef SIMON_CHAIN_EN
                  blk_d = blk_in ^ iv_q;
`else
                  blk_d = blk_in;
`endif
                  cnt_d   = '0;
                  wk_d    = key_q;
                  rnd_d   = '0;
                  state_d = RUN;
                end else begin
                  blk_d = blk_in;
                  cnt_d = cnt_q + 1'b1;
                end
              end
              SEL_IV: begin
`ifdef SIMON_CHAIN_EN
                iv_d = {iv_q[BW-9:0], in_data};
`endif
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          blk_d = {x_n, y_n};
          wk_d  = {knew, wk_q[KW-1:N]};
          if (rnd_q == RW'(T - 1)) begin
            rnd_d   = '0;
            state_d = UNLOAD;
          end else begin
            rnd_d = rnd_q + 1'b1;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            if (cnt_q == CW'(NB - 1)) begin
              cnt_d   = '0;
              state_d = IDLE;
`ifdef SIMON_CHAIN_EN
              iv_d    = blk_q;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      wk_q    <= '0;
      blk_q   <= '0;
      cnt_q   <= '0;
      rnd_q   <= '0;
`ifdef SIMON_CHAIN_EN
      iv_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      wk_q    <= wk_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
`ifdef SIMON_CHAIN_EN
      iv_q    <= iv_d;
`endif
    end
  end

endmodule

// File: tb/tb_simon_stream_core.sv
// Directed self-checking bench for simon_stream_core (default ECB build, Simon32/64).
module tb_simon_stream_core;

  localparam int unsigned N    = 16;
  localparam int unsigned M    = 4;
  localparam int unsigned T    = 32;
  localparam int unsigned ZSEQ = 0;
  localparam int unsigned NB   = 4;
  localparam int unsigned KB   = 8;

  localparam logic [61:0] ZT [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_sel = 2'b00;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int got_cnt = 0;
  logic [7:0] exp_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  simon_stream_core #(.N(N), .M(M), .T(T), .ZSEQ(ZSEQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] w, input int unsigned s,
                                       input int unsigned n);
    logic [63:0] msk;
    msk = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    w = w & msk;
    return ((w << s) | (w >> (n - s))) & msk;
  endfunction

  // Textbook Simon: expand the whole key schedule, then run T rounds.
  function automatic logic [127:0] model_enc(input int unsigned n, input int unsigned m,
                                             input int unsigned t, input int unsigned zs,
                                             input logic [255:0] key, input logic [127:0] pt);
    logic [63:0] msk, x, y, tmp;
    logic [63:0] k [0:127];
    logic [61:0] zc;
    msk = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    zc  = ZT[zs];
    for (int i = 0; i < int'(m); i++) k[i] = 64'(key >> (i * n)) & msk;
    for (int i = int'(m); i < int'(t); i++) begin
      tmp = rotl(k[i-1], n - 3, n);
      if (m == 4) tmp = tmp ^ k[i-3];
      tmp = tmp ^ rotl(tmp, n - 1, n);
      k[i] = (~k[i-int'(m)] ^ tmp ^ 64'(zc[61 - ((i - int'(m)) % 62)]) ^ 64'd3) & msk;
    end
    x = 64'(pt >> n) & msk;
    y = 64'(pt) & msk;
    for (int i = 0; i < int'(t); i++) begin
      tmp = x;
      x = (y ^ (rotl(x, 1, n) & rotl(x, 8, n)) ^ rotl(x, 2, n) ^ k[i]) & msk;
      y = tmp;
    end
    return (128'(x) << n) | 128'(y);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev && ena) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, data_prev);
      end
      if (out_valid && out_ready) begin
        check("byte_expected", 128'(exp_q.size() > 0), 128'd1);
        if (exp_q.size() > 0) begin
          check("out_byte", out_data, exp_q.pop_front());
          got_cnt++;
        end
      end
      if (!ena) check("ena_low_out_valid", out_valid, 1'b0);
      if (!busy) check("idle_out_data", out_data, 8'h00);
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [1:0] sel, input logic [7:0] b);
    int guard;
    logic acc;
    in_sel = sel;
    in_data = b;
    in_valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      if (acc) break;
      guard++;
      if (guard > 300) begin
        fail("in_ready_timeout");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_key(input logic [63:0] k);
    for (int i = KB - 1; i >= 0; i--) send_byte(2'b00, k[8*i +: 8]);
  endtask

  task automatic push_exp(input logic [63:0] k, input logic [31:0] pt);
    logic [127:0] ct;
    ct = model_enc(N, M, T, ZSEQ, 256'(k), 128'(pt));
    for (int i = NB - 1; i >= 0; i--) exp_q.push_back(ct[8*i +: 8]);
  endtask

  task automatic send_block(input logic [63:0] k, input logic [31:0] pt, input bit expect_out);
    if (expect_out) push_exp(k, pt);
    for (int i = NB - 1; i >= 0; i--) send_byte(2'b01, pt[8*i +: 8]);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0 || busy) begin
      fail("drain_timeout");
      exp_q.delete();
    end
  endtask

  task automatic measure_latency(input int req);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    if (out_valid) check("latency", 128'(cyc - acc_cyc), 128'(req));
    else fail("latency_timeout");
  endtask

  initial begin
    logic [63:0] k1, k2;
    int base;
    k1 = 64'h1918_1110_0908_0100;
    k2 = 64'h0f1e_2d3c_4b5a_6978;

    check("model_simon32_64", model_enc(16, 4, 32, 0, 256'h1918111009080100, 128'h65656877),
          128'hc69be9bb);
    check("model_simon64_128",
          model_enc(32, 4, 44, 3, 256'h1b1a1918131211100b0a090803020100, 128'h656b696c20646e75),
          128'h44c8fc20b9dfa07a);

    ena = 1'b1;
    tick(3);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick(1);
    check("idle_in_ready", in_ready, 1'b1);

    // Reference vector and latency
    send_key(k1);
    send_block(k1, 32'h6565_6877, 1'b1);
    check("busy_run", busy, 1'b1);
    check("in_ready_run", in_ready, 1'b0);
    measure_latency(T + 1);
    wait_drain(200);

    // Same key again, with a 10-cycle stall mid-unload
    base = got_cnt;
    send_block(k1, 32'h0123_4567, 1'b1);
    begin
      int n;
      n = 0;
      while (got_cnt < base + 2 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (got_cnt < base + 2) fail("stall_wait_timeout");
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tick(10);
    out_ready = 1'b1;
    wait_drain(200);
    check("stall_byte_count", 128'(got_cnt - base), 128'd4);

    // ena low for 5 cycles mid-RUN
    send_block(k1, 32'hdead_beef, 1'b1);
    tick(9);
    ena = 1'b0;
    tick(2);
    check("ena_low_in_ready", in_ready, 1'b0);
    check("ena_low_busy", busy, 1'b1);
    tick(3);
    ena = 1'b1;
    measure_latency(T + 1 + 5);
    wait_drain(200);

    // Partial block discarded by a key byte; junk key byte shifted out
    send_byte(2'b01, 8'haa);
    send_byte(2'b01, 8'hbb);
    send_byte(2'b01, 8'hcc);
    send_byte(2'b00, 8'h5a);
    send_key(k2);
    send_block(k2, 32'h1357_9bdf, 1'b1);
    wait_drain(200);

    // Reserved and IV selects are dropped in the ECB build
    push_exp(k2, 32'hc0ff_ee11);
    send_byte(2'b01, 8'hc0);
    send_byte(2'b11, 8'hff);
    send_byte(2'b01, 8'hff);
    send_byte(2'b10, 8'hee);
    send_byte(2'b11, 8'h00);
    send_byte(2'b01, 8'hee);
    send_byte(2'b01, 8'h11);
    wait_drain(200);

    // Reset mid-RUN clears everything including the master key
    send_block(k2, 32'h2468_ace0, 1'b0);
    tick(5);
    rst_n = 1'b0;
    #2;
    check("midrun_rst_in_ready", in_ready, 1'b0);
    check("midrun_rst_out_valid", out_valid, 1'b0);
    check("midrun_rst_out_data", out_data, 8'h00);
    check("midrun_rst_busy", busy, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_in_ready", in_ready, 1'b1);
    send_block(64'h0, 32'h6565_6877, 1'b1);
    measure_latency(T + 1);
    wait_drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

endmodule
